// File: rtl/voice_mixer_core.sv
// 256-voice time-multiplexed DDS sawtooth synthesizer with a per-frame mixer.
// One voice is processed per clock; each 256-clock frame yields one summed sample.
module voice_mixer_core #(
    parameter int NUM_VOICES = 256,
    parameter int PHASE_W    = 32,
    parameter int WAVE_W     = 16,
    parameter int OUT_W      = 24
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_SPI_note_status,
    input  logic [7:0]                i_SPI_voice_index,
    input  logic [PHASE_W-1:0]        i_SPI_tuning_code,
    input  logic [6:0]                i_SPI_velocity,
    input  logic                      i_SPI_flag,
    output logic signed [OUT_W-1:0]   o_mixed_sample
);

    localparam int VEL_W = 7;
    localparam int CFG_W = PHASE_W + VEL_W;

    logic [7:0]               cnt;
    logic                     active [NUM_VOICES];
    logic [PHASE_W-1:0]       phase  [NUM_VOICES];
    // Per-voice patch word: {velocity, tune}. Velocity rides along for a later revision.
    logic [CFG_W-1:0]         cfg    [NUM_VOICES];
    logic signed [OUT_W-1:0]  acc;
    logic signed [WAVE_W-1:0] wave;
    logic signed [OUT_W-1:0]  contrib;

    function automatic logic signed [WAVE_W-1:0] saw(input logic [PHASE_W-1:0] p);
        return {~p[PHASE_W-1], p[PHASE_W-2 -: WAVE_W-1]};
    endfunction

    function automatic logic signed [OUT_W-1:0] sext(input logic signed [WAVE_W-1:0] w);
        return {{(OUT_W-WAVE_W){w[WAVE_W-1]}}, w};
    endfunction

    // Contribution is formed from pre-command state, so a same-cycle command cannot affect it.
    always_comb begin
        wave    = '0;
        if (active[cnt]) begin
            wave = saw(phase[cnt]);
        end
        contrib = sext(wave);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt            <= '0;
            acc            <= '0;
            o_mixed_sample <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                active[i] <= 1'b0;
                phase[i]  <= '0;
                cfg[i]    <= '0;
            end
        end else begin
            cnt <= cnt + 8'd1;

            if (active[cnt]) begin
                phase[cnt] <= phase[cnt] + cfg[cnt][PHASE_W-1:0];
            end

            // Later non-blocking writes win, giving commands priority over the phase step.
            if (i_SPI_flag) begin
                if (i_SPI_note_status) begin
                    cfg[i_SPI_voice_index]    <= {i_SPI_velocity, i_SPI_tuning_code};
                    phase[i_SPI_voice_index]  <= '0;
                    active[i_SPI_voice_index] <= 1'b1;
                end else begin
                    active[i_SPI_voice_index] <= 1'b0;
                end
            end

            if (cnt == 8'd0) begin
                acc <= contrib;
            end else begin
                acc <= acc + contrib;
            end

            if (cnt == 8'd255) begin
                o_mixed_sample <= acc + contrib;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer_core.sv
// Scoreboard bench for voice_mixer_core: stimulus pushes expected frame sums,
// a monitor pops and compares at every frame boundary.
module tb_voice_mixer_core;

    logic               clk;
    logic               rst;
    logic               note;
    logic [7:0]         idx;
    logic [31:0]        tune;
    logic [6:0]         vel;
    logic               flag;
    logic signed [23:0] mixed;

    logic [7:0]         vcnt;
    int                 exp_q[$];
    int                 n_vec;
    int                 n_bad;
    logic               fe;
    int                 e;

    voice_mixer_core dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_SPI_note_status (note),
        .i_SPI_voice_index (idx),
        .i_SPI_tuning_code (tune),
        .i_SPI_velocity    (vel),
        .i_SPI_flag        (flag),
        .o_mixed_sample    (mixed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent voice counter: value seen at a negedge is the voice processed on the next posedge.
    always @(posedge clk) begin
        if (rst) vcnt <= 8'd0;
        else     vcnt <= vcnt + 8'd1;
    end

    always begin
        @(posedge clk);
        fe = !rst && (vcnt == 8'd255);
        #1;
        if (fe && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (int'(mixed) != e) begin
                n_bad++;
                $display("FAIL frame_sample: got %0d expected %0d", mixed, e);
            end
        end
    end

    task automatic wait_vcnt(input logic [7:0] v);
        int b = 0;
        @(negedge clk);
        while (vcnt != v && b < 600) begin
            @(negedge clk);
            b++;
        end
        if (vcnt != v) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_vcnt_timeout: counter %0d expected %0d", vcnt, v);
        end
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() > 0 && b < 20000) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d frames pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic on, input logic [7:0] v, input logic [31:0] t);
        note = on;
        idx  = v;
        tune = t;
        vel  = 7'd100;
        flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
    endtask

    task automatic check_direct(input string name, input int want);
        n_vec++;
        if (int'(mixed) != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, mixed, want);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        note  = 1'b0;
        idx   = 8'd0;
        tune  = 32'd0;
        vel   = 7'd0;
        flag  = 1'b0;

        // Reset held 5 cycles, then silence for four frames
        repeat (5) @(negedge clk);
        check_direct("reset_out", 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(0);
        drain();

        // Voice 253 sawtooth with tune 0x10000000: +4096 per frame, wraps after 16
        wait_vcnt(8'd10);
        for (int i = 0; i < 16; i++) exp_q.push_back(-32768 + 4096 * i);
        exp_q.push_back(-32768);
        issue(1'b1, 8'd253, 32'h1000_0000);
        drain();

        // Retrigger with tune 20000000
        wait_vcnt(8'd10);
        exp_q.push_back(-32768);
        exp_q.push_back(-32463);
        exp_q.push_back(-32158);
        issue(1'b1, 8'd253, 32'd20000000);
        drain();

        // Note off landing on voice 253's own cycle: this frame still carries it
        wait_vcnt(8'd253);
        exp_q.push_back(-31853);
        exp_q.push_back(0);
        exp_q.push_back(0);
        issue(1'b0, 8'd253, 32'd0);
        drain();

        wait_vcnt(8'd10);
        exp_q.push_back(-32768);
        exp_q.push_back(-32463);
        issue(1'b1, 8'd253, 32'd20000000);
        drain();
        wait_vcnt(8'd10);
        exp_q.push_back(0);
        issue(1'b0, 8'd253, 32'd0);
        drain();

        // Voices 0 and 255 with tune 0; voice 0 already processed in the issuing frame
        wait_vcnt(8'd10);
        exp_q.push_back(-32768);
        exp_q.push_back(-65536);
        exp_q.push_back(-65536);
        issue(1'b1, 8'd0, 32'd0);
        issue(1'b1, 8'd255, 32'd0);
        drain();
        wait_vcnt(8'd10);
        exp_q.push_back(-65536);
        exp_q.push_back(-32768);
        exp_q.push_back(-32768);
        issue(1'b0, 8'd0, 32'd0);
        drain();
        wait_vcnt(8'd10);
        exp_q.push_back(0);
        issue(1'b0, 8'd255, 32'd0);
        drain();

        // All voices on with tune 0x80000000, each command colliding with its own voice
        wait_vcnt(8'd0);
        for (int i = 0; i < 256; i++) begin
            note = 1'b1;
            idx  = 8'(i);
            tune = 32'h8000_0000;
            vel  = 7'(i);
            flag = 1'b1;
            if (i == 128) begin
                exp_q.push_back(0);
                exp_q.push_back(-8388608);
                exp_q.push_back(0);
                exp_q.push_back(-8388608);
            end
            @(negedge clk);
        end
        flag = 1'b0;
        drain();

        // One unchecked frame returns all phases to 0; the off sweep sees full negative sum
        wait_vcnt(8'd0);
        for (int i = 0; i < 256; i++) begin
            note = 1'b0;
            idx  = 8'(i);
            flag = 1'b1;
            if (i == 128) begin
                exp_q.push_back(-8388608);
                exp_q.push_back(0);
            end
            @(negedge clk);
        end
        flag = 1'b0;
        drain();

        // Note on for voice 5 issued while voice 5 is being processed
        wait_vcnt(8'd5);
        exp_q.push_back(0);
        exp_q.push_back(-32768);
        exp_q.push_back(-32768);
        issue(1'b1, 8'd5, 32'd0);
        drain();

        // Mid-frame reset clears output and all voices
        wait_vcnt(8'd100);
        rst = 1'b1;
        @(negedge clk);
        check_direct("midframe_reset_out", 0);
        rst = 1'b0;
        exp_q.push_back(0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
